// File: rtl/reglk_bus_gate_if.sv
// ============================================================================
// reglk_bus_gate_if : request/response handshake bundle for reglk_bus_gate
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reglk_bus_gate_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_width;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;

   modport master (
      output req_valid, req_we, req_width, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_width, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

`default_nettype wire

// File: rtl/reglk_bus_gate.sv
// ============================================================================
// reglk_bus_gate : sticky per-region write-lock gate in front of a data memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module reglk_bus_gate #(
   parameter int          NUM_WORDS    = 200,
   parameter int          REGION_SHIFT = 7,
   parameter int          NUM_REGIONS  = 8,
   parameter logic [31:0] LOCK_ADDR    = 32'h0000_0400
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   reglk_bus_gate_if.slave             bus,
   output logic                        mem_we,
   output logic [2:0]                  mem_width,
   output logic [31:0]                 mem_addr,
   output logic [31:0]                 mem_wdata,
   input  wire logic [31:0]            mem_rdata,
   output logic [NUM_REGIONS-1:0]      lock_status
);

   localparam int c_RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ISSUE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic                   r_cap_we;
   logic [2:0]             r_cap_width;
   logic [31:0]            r_cap_addr;
   logic [31:0]            r_cap_wdata;
   logic [31:0]            r_rsp_rdata;
   logic [1:0]             r_rsp_err;
   logic [NUM_REGIONS-1:0] r_lock;

   logic                   w_bad_width;
   logic                   w_lock_access;
   logic                   w_out_of_range;
   logic                   w_misaligned;
   logic [31:0]            w_region;
   logic                   w_locked;
   logic [1:0]             w_err;
   logic [31:0]            w_rdata;
   logic [NUM_REGIONS-1:0] w_lock_set;
   logic                   w_forward;

   assign w_bad_width    = (r_cap_width == 3'b011) || (r_cap_width == 3'b110) ||
                           (r_cap_width == 3'b111);
   assign w_lock_access  = (r_cap_addr == LOCK_ADDR);
   assign w_out_of_range = ({2'b00, r_cap_addr[31:2]} >= 32'(NUM_WORDS));
   assign w_misaligned   = ((r_cap_width[1:0] == 2'b01) && r_cap_addr[0]) ||
                           ((r_cap_width == 3'b010) && (r_cap_addr[1:0] != 2'b00));
   assign w_region       = r_cap_addr >> REGION_SHIFT;
   assign w_locked       = (w_region < 32'(NUM_REGIONS)) && r_lock[w_region[c_RIDX_W-1:0]];

   // Decode priority: width, lock register, range, alignment, lock.
   always_comb begin
      w_next_state = r_state;
      w_err        = 2'b00;
      w_rdata      = '0;
      w_lock_set   = '0;
      w_forward    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.req_valid) w_next_state = CHECK;
         end
         CHECK: begin
            if (w_bad_width) begin
               w_err = 2'b11;
            end else if (w_lock_access) begin
               if (r_cap_width != 3'b010)  w_err = 2'b11;
               else if (r_cap_we)          w_lock_set = r_cap_wdata[NUM_REGIONS-1:0];
               else                        w_rdata[NUM_REGIONS-1:0] = r_lock;
            end else if (w_out_of_range) begin
               w_err = 2'b10;
            end else if (w_misaligned) begin
               w_err = 2'b11;
            end else if (r_cap_we && w_locked) begin
               w_err = 2'b01;
            end else begin
               w_forward = 1'b1;
            end
            w_next_state = w_forward ? ISSUE : RESP;
         end
         ISSUE:   w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cap_we    <= 1'b0;
         r_cap_width <= 3'b010;
         r_cap_addr  <= '0;
         r_cap_wdata <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 2'b00;
         r_lock      <= '0;
         mem_we      <= 1'b0;
         mem_width   <= 3'b010;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         if ((r_state == IDLE) && bus.req_valid) begin
            r_cap_we    <= bus.req_we;
            r_cap_width <= bus.req_width;
            r_cap_addr  <= bus.req_addr;
            r_cap_wdata <= bus.req_wdata;
         end
         if (r_state == CHECK) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= w_rdata;
            r_lock      <= r_lock | w_lock_set;
            if (w_forward) begin
               mem_we    <= r_cap_we;
               mem_width <= r_cap_width;
               mem_addr  <= r_cap_addr;
               mem_wdata <= r_cap_wdata;
            end
         end
         // The memory read path is combinational, so sample it as ISSUE ends.
         if (r_state == ISSUE) begin
            mem_we      <= 1'b0;
            r_rsp_rdata <= r_cap_we ? 32'h0 : mem_rdata;
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign lock_status   = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_reglk_bus_gate.sv
// ============================================================================
// tb_reglk_bus_gate : directed + random checks of reglk_bus_gate vs a byte model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reglk_bus_gate;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_we;
   logic [2:0]  mem_width;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [7:0]  lock_status;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reglk_bus_gate_if bus ();

   reglk_bus_gate #(
      .NUM_WORDS    (200),
      .REGION_SHIFT (7),
      .NUM_REGIONS  (8),
      .LOCK_ADDR    (32'h0000_0400)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mem_we      (mem_we),
      .mem_width   (mem_width),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .lock_status (lock_status)
   );

   // Downstream memory: word storage, negedge write, combinational formatted read.
   logic [31:0] mem_words [200];
   logic [31:0] mw;
   logic [31:0] msh;

   always @(negedge clk) begin
      if (mem_we && mem_addr < 32'd800) begin
         case (mem_width[1:0])
            2'b00:   mem_words[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
            2'b01:   mem_words[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
            default: mem_words[mem_addr[9:2]] <= mem_wdata;
         endcase
      end
   end

   always_comb begin
      mw  = (mem_addr < 32'd800) ? mem_words[mem_addr[9:2]] : 32'h0;
      msh = mw >> {mem_addr[1:0], 3'b000};
      case (mem_width)
         3'b000:  mem_rdata = {{24{msh[7]}}, msh[7:0]};
         3'b001:  mem_rdata = {{16{msh[15]}}, msh[15:0]};
         3'b100:  mem_rdata = {24'h0, msh[7:0]};
         3'b101:  mem_rdata = {16'h0, msh[15:0]};
         default: mem_rdata = mw;
      endcase
   end

   // Reference model: flat byte array plus lock byte.
   logic [7:0] ref_b [800];
   logic [7:0] ref_lock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic we, input logic [2:0] width, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [1:0] err,
                        output logic [31:0] rdata, output logic fwd);
      int n;
      logic [31:0] v;
      err = 2'd0; rdata = 32'h0; fwd = 1'b0;
      n = (width[1:0] == 2'b00) ? 1 : (width[1:0] == 2'b01) ? 2 : 4;
      if (width == 3'd3 || width >= 3'd6) err = 2'd3;
      else if (addr == 32'h400) begin
         if (width != 3'd2) err = 2'd3;
         else if (we)       ref_lock = ref_lock | wdata[7:0];
         else               rdata = {24'h0, ref_lock};
      end
      else if (addr / 4 >= 200) err = 2'd2;
      else if ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0)) err = 2'd3;
      else if (we && ref_lock[addr / 128]) err = 2'd1;
      else begin
         fwd = 1'b1;
         if (we) begin
            for (int i = 0; i < n; i++) ref_b[addr + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[addr + i]) << (8 * i));
            if (!width[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rdata = v;
         end
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata);
      logic [1:0]  e_err;
      logic [31:0] e_rdata;
      logic        e_fwd;
      int          n, lat, wes;
      bit          got;
      model(we, width, addr, wdata, e_err, e_rdata, e_fwd);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_width = width;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      n = 0;
      while (!bus.req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'h1);
      lat = 0; wes = 0; got = 1'b0;
      for (int c = 1; c <= 6 && !got; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (mem_we) begin
            wes++;
            chk({tag, "_mem_addr"}, mem_addr, addr);
            chk({tag, "_mem_wdata"}, mem_wdata, wdata);
         end
         if (bus.rsp_valid) begin
            got = 1'b1;
            lat = c;
         end
      end
      chk({tag, "_rsp_seen"}, 32'(got), 32'h1);
      chk({tag, "_latency"}, 32'(lat), e_fwd ? 32'd3 : 32'd2);
      chk({tag, "_mem_we_cycles"}, 32'(wes), (e_fwd && we) ? 32'd1 : 32'd0);
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e_err));
      chk({tag, "_rdata"}, bus.rsp_rdata, e_rdata);
      chk({tag, "_lock"}, 32'(lock_status), 32'(ref_lock));
   endtask

   initial begin
      logic [31:0] q_addr [$];
      logic [31:0] q_data [$];
      logic [31:0] a, d;
      logic [2:0]  w;
      logic        we;
      logic [1:0]  e_err;
      logic [31:0] e_rdata;
      logic        e_fwd;
      int          pushes, rsps, sel;

      for (int i = 0; i < 200; i++) mem_words[i] = 32'h0;
      for (int i = 0; i < 800; i++) ref_b[i] = 8'h0;
      ref_lock = 8'h0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_width = 3'b010;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_width", 32'(mem_width), 32'h2);
      chk("rst_lock", 32'(lock_status), 32'h0);
      rst = 1'b0;

      // Basic write/read and lock enforcement
      do_req("wr10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      do_req("rd10", 1'b0, 3'b010, 32'h10, 32'h0);
      do_req("wr40", 1'b1, 3'b010, 32'h40, 32'h1234_5678);
      do_req("lock1", 1'b1, 3'b010, 32'h400, 32'h0000_0001);
      do_req("wr40_locked", 1'b1, 3'b010, 32'h40, 32'hFFFF_0000);
      do_req("rd40_locked", 1'b0, 3'b010, 32'h40, 32'h0);
      do_req("lock0", 1'b1, 3'b010, 32'h400, 32'h0000_0000);
      do_req("rd_lockreg", 1'b0, 3'b010, 32'h400, 32'h0);
      do_req("lock_ub", 1'b1, 3'b100, 32'h400, 32'h0000_00FF);

      // Decode errors
      do_req("oor_320", 1'b0, 3'b010, 32'h320, 32'h0);
      do_req("sh_11", 1'b0, 3'b001, 32'h11, 32'h0);
      do_req("width3", 1'b0, 3'b011, 32'h10, 32'h0);
      do_req("sb_rd11", 1'b0, 3'b000, 32'h11, 32'h0);

      // Backpressure: valid held with a new address every cycle
      pushes = 0; rsps = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            rsps++;
            if (q_addr.size() == 0) begin
               chk("bp_unexpected_rsp", 32'h1, 32'h0);
            end else begin
               chk("bp_addr", mem_addr, q_addr.pop_front());
               chk("bp_rdata", bus.rsp_rdata, q_data.pop_front());
            end
         end
         if (k < 16) begin
            a = 32'($urandom_range(0, 199)) << 2;
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_width = 3'b010;
            bus.req_addr  = a;
            if (bus.req_ready) begin
               pushes++;
               model(1'b0, 3'b010, a, 32'h0, e_err, e_rdata, e_fwd);
               q_addr.push_back(a);
               q_data.push_back(e_rdata);
            end
         end else begin
            bus.req_valid = 1'b0;
         end
      end
      chk("bp_accepts", 32'(pushes), 32'd4);
      chk("bp_responses", 32'(rsps), 32'd4);

      // Reset during ISSUE of a write to unlocked region 1
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_width = 3'b010;
      bus.req_addr  = 32'h80;
      bus.req_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("mid_issue_we", 32'(mem_we), 32'h1);
      for (int i = 0; i < 4; i++) ref_b[32'h80 + i] = 8'(32'hCAFE_F00D >> (8 * i));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_we", 32'(mem_we), 32'h0);
      chk("mid_rst_lock", 32'(lock_status), 32'h0);
      chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'h0);
      rst = 1'b0;
      ref_lock = 8'h0;
      sel = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid) sel++;
      end
      chk("mid_rst_no_rsp", 32'(sel), 32'h0);
      do_req("rd80_after_rst", 1'b0, 3'b010, 32'h80, 32'h0);
      do_req("wr00_after_rst", 1'b1, 3'b000, 32'h3, 32'h0000_0081);

      // Random traffic
      for (int t = 0; t < 200; t++) begin
         sel = $urandom_range(0, 15);
         w   = 3'($urandom_range(0, 7));
         we  = 1'($urandom_range(0, 1));
         d   = $urandom();
         if (sel == 0) begin
            a = 32'h400;
            if ($urandom_range(0, 3) != 0) w = 3'b010;
            d = (d & 32'hFFFF_FF00) | (32'h1 << $urandom_range(0, 7));
         end else if (sel == 1) begin
            a = 32'($urandom_range(800, 1100));
         end else begin
            a = 32'($urandom_range(0, 799));
            if ($urandom_range(0, 3) != 0) begin
               if (w[1:0] == 2'b01) a = a & ~32'h1;
               if (w == 3'b010)     a = a & ~32'h3;
            end
         end
         do_req("rand", we, w, a, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
